// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder a + b + c -> {cout, sum}, with a registered
// copy of the result (plus signed overflow) captured on in_valid.
module full_adder #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             valid_q
);

  logic [WIDTH:0] k;
  logic           ovf;

  assign k[0] = c;

  // Each bit is one classic full-adder cell; carries ripple LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i]  = a[i] ^ b[i] ^ k[i];
    assign k[i+1]  = (a[i] & b[i]) | (k[i] & (a[i] ^ b[i]));
  end

  assign cout = k[WIDTH];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf  = k[WIDTH] ^ k[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (in_valid) begin
      sum_q   <= sum;
      cout_q  <= cout;
      ovf_q   <= ovf;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: WIDTH=1 exhaustive and registered path,
// WIDTH=4 directed vectors, WIDTH=8 random stream through a scoreboard.
`timescale 1ns/1ps
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;

  // WIDTH=1 instance
  logic [0:0] a1, b1, sum1, sum1_q;
  logic       c1, in_valid1, cout1, cout1_q, ovf1_q, valid1_q;

  // WIDTH=4 instance
  logic [3:0] a4, b4, sum4, sum4_q;
  logic       c4, in_valid4, cout4, cout4_q, ovf4_q, valid4_q;

  // WIDTH=8 instance
  logic [7:0] a8, b8, sum8, sum8_q;
  logic       c8, in_valid8, cout8, cout8_q, ovf8_q, valid8_q;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0] sb[$];
  logic       exp_v8 = 1'b0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut1 (
    .sum(sum1), .cout(cout1), .a(a1), .b(b1), .c(c1),
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
    .sum_q(sum1_q), .cout_q(cout1_q), .ovf_q(ovf1_q), .valid_q(valid1_q)
  );

  full_adder #(.WIDTH(4)) dut4 (
    .sum(sum4), .cout(cout4), .a(a4), .b(b4), .c(c4),
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4),
    .sum_q(sum4_q), .cout_q(cout4_q), .ovf_q(ovf4_q), .valid_q(valid4_q)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .sum(sum8), .cout(cout8), .a(a8), .b(b8), .c(c8),
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8),
    .sum_q(sum8_q), .cout_q(cout8_q), .ovf_q(ovf8_q), .valid_q(valid8_q)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic b, input logic c,
                               input logic v);
    @(negedge clk);
    a1        = a;
    b1        = b;
    c1        = c;
    in_valid1 = v;
  endtask

  // Reference model of the WIDTH=8 registered valid flag.
  always @(posedge clk) exp_v8 <= in_valid8 && rst_n;

  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      checkOutput("w8_valid_q", {31'b0, valid8_q}, {31'b0, exp_v8});
      if (exp_v8) begin
        checkOutput("w8_sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("w8_q", {22'b0, ovf8_q, cout8_q, sum8_q}, {22'b0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [1:0] exp_tab[8];
    logic [2:0] vec;
    logic [2:0] pulse[3];
    logic [2:0] pulse_exp[3];
    logic [8:0] full;
    logic [7:0] low;
    logic       ovf;

    // {sum, cout} for {a,b,c} = 0..7
    exp_tab   = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    // {a,b,c} and expected {sum_q, cout_q, ovf_q}
    pulse     = '{3'b100, 3'b110, 3'b001};
    pulse_exp = '{3'b100, 3'b011, 3'b101};

    rst_n = 1'b0;
    a1 = '0; b1 = '0; c1 = 1'b0; in_valid1 = 1'b0;
    a4 = '0; b4 = '0; c4 = 1'b0; in_valid4 = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0; in_valid8 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_sum1_q",   {31'b0, sum1_q},   32'd0);
    checkOutput("rst_cout1_q",  {31'b0, cout1_q},  32'd0);
    checkOutput("rst_ovf1_q",   {31'b0, ovf1_q},   32'd0);
    checkOutput("rst_valid1_q", {31'b0, valid1_q}, 32'd0);
    checkOutput("rst_sum8_q",   {24'b0, sum8_q},   32'd0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec = i[2:0];
      a1 = vec[2]; b1 = vec[1]; c1 = vec[0];
      #2;
      checkOutput($sformatf("w1_sum_%0d", i),  {31'b0, sum1},  {31'b0, exp_tab[i][1]});
      checkOutput($sformatf("w1_cout_%0d", i), {31'b0, cout1}, {31'b0, exp_tab[i][0]});
      checkOutput($sformatf("w1_ovf_%0d", i),  {31'b0, dut1.ovf},
                  {31'b0, exp_tab[i][0] ^ vec[0]});
    end

    @(negedge clk);
    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    #2;
    checkOutput("w4_wrap_sum",  {28'b0, sum4}, 32'h0);
    checkOutput("w4_wrap_cout", {31'b0, cout4}, 32'd1);
    a4 = 4'h7; b4 = 4'h1; c4 = 1'b0;
    #2;
    checkOutput("w4_ovf_sum",  {28'b0, sum4}, 32'h8);
    checkOutput("w4_ovf_cout", {31'b0, cout4}, 32'd0);
    checkOutput("w4_ovf",      {31'b0, dut4.ovf}, 32'd1);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    #2;
    checkOutput("w4_allones", {27'b0, cout4, sum4}, 32'h1F);

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    checkOutput("reg_first_sum",   {31'b0, sum1_q},   32'd1);
    checkOutput("reg_first_cout",  {31'b0, cout1_q},  32'd1);
    checkOutput("reg_first_ovf",   {31'b0, ovf1_q},   32'd0);
    checkOutput("reg_first_valid", {31'b0, valid1_q}, 32'd1);

    for (int p = 0; p < 3; p++) begin
      applyStimulus(pulse[p][2], pulse[p][1], pulse[p][0], 1'b1);
      @(posedge clk); #1;
      checkOutput($sformatf("burst_valid_%0d", p), {31'b0, valid1_q}, 32'd1);
      checkOutput($sformatf("burst_q_%0d", p), {29'b0, sum1_q, cout1_q, ovf1_q},
                  {29'b0, pulse_exp[p]});
    end

    for (int h = 0; h < 2; h++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      checkOutput($sformatf("hold_valid_%0d", h), {31'b0, valid1_q}, 32'd0);
      checkOutput($sformatf("hold_q_%0d", h), {29'b0, sum1_q, cout1_q, ovf1_q},
                  {29'b0, pulse_exp[2]});
    end

    // Reset and capture on the same edge: reset must win.
    @(negedge clk);
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstprio_valid", {31'b0, valid1_q}, 32'd0);
    checkOutput("rstprio_sum",   {31'b0, sum1_q},   32'd0);
    checkOutput("rstprio_cout",  {31'b0, cout1_q},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid1 = 1'b0;

    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (n == 0) begin
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; in_valid8 = 1'b1;
      end else begin
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        c8 = 1'($urandom_range(0, 1));
        in_valid8 = ($urandom_range(0, 3) != 0);
      end
      rst_n = !(n == 500 || n == 501);
      full = {1'b0, a8} + {1'b0, b8} + {8'b0, c8};
      low  = {1'b0, a8[6:0]} + {1'b0, b8[6:0]} + {7'b0, c8};
      ovf  = full[8] ^ low[7];
      if (in_valid8 && rst_n) sb.push_back({ovf, full});
      #2;
      checkOutput("w8_comb", {23'b0, cout8, sum8}, {23'b0, full});
    end

    @(negedge clk);
    in_valid8 = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("w8_sb_drain", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
